// File: rtl/sdrc_app_arb.sv
// Four-port request arbiter in front of the SDRAM controller application port.
// Grants one requester at a time and steers later data phases via owner-tag FIFOs.
module sdrc_app_arb #(
    parameter int APP_AW = 30,
    parameter int APP_DW = 32,
    parameter int APP_BW = 4,
    parameter int BL     = 9,
    parameter int TDEPTH = 4
) (
    input  logic                  sdram_clk,
    input  logic                  sdram_rst,
    input  logic                  cfg_arb_mode,
    input  logic [3:0]            p_req,
    input  logic [4*APP_AW-1:0]   p_req_addr,
    input  logic [4*BL-1:0]       p_req_len,
    input  logic [3:0]            p_req_wr_n,
    output logic [3:0]            p_req_ack,
    input  logic [4*APP_DW-1:0]   p_wr_data,
    input  logic [4*APP_BW-1:0]   p_wr_en_n,
    output logic [3:0]            p_wr_next,
    output logic [3:0]            p_rd_valid,
    output logic [3:0]            p_last_rd,
    output logic [APP_DW-1:0]     p_rd_data,
    output logic                  app_req,
    output logic [APP_AW-1:0]     app_req_addr,
    output logic [BL-1:0]         app_req_len,
    output logic                  app_req_wr_n,
    input  logic                  app_req_ack,
    output logic [APP_DW-1:0]     app_wr_data,
    output logic [APP_BW-1:0]     app_wr_en_n,
    input  logic                  app_wr_next_req,
    input  logic                  app_last_wr,
    input  logic                  app_rd_valid,
    input  logic                  app_last_rd,
    input  logic [APP_DW-1:0]     app_rd_data,
    output logic                  arb_busy,
    output logic                  err_orphan
);
    localparam int PW = $clog2(TDEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(TDEPTH);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_grant, r_last_grant, w_pick;
    logic                w_pick_vld, w_grant_ld, w_accept;
    logic [APP_AW-1:0]   r_addr;
    logic [BL-1:0]       r_len;
    logic                r_wr_n;
    logic [3:0]          w_elig;
    logic                r_err;

    logic [1:0]          r_wq [TDEPTH];
    logic [1:0]          r_rq [TDEPTH];
    logic [PW-1:0]       r_wq_wp, r_wq_rp, r_rq_wp, r_rq_rp;
    logic [PW:0]         r_wq_cnt, r_rq_cnt;
    logic                w_wq_empty, w_rq_empty;
    logic                w_wq_push, w_wq_pop, w_rq_push, w_rq_pop;
    logic [1:0]          w_wq_head, w_rq_head;

    assign w_wq_empty = (r_wq_cnt == '0);
    assign w_rq_empty = (r_rq_cnt == '0);
    assign w_wq_head  = r_wq[r_wq_rp];
    assign w_rq_head  = r_rq[r_rq_rp];

    // A port is only eligible if the tag FIFO for its direction has room.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_elig[i] = p_req[i] & (p_req_wr_n[i] ? (r_rq_cnt < FULL) : (r_wq_cnt < FULL));
        end
    end

    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        if (cfg_arb_mode) begin
            for (int i = 3; i >= 0; i--) begin
                if (w_elig[i]) begin
                    w_pick     = 2'(i);
                    w_pick_vld = 1'b1;
                end
            end
        end else begin
            // Descending offset so the port nearest after last_grant is assigned last and wins.
            for (int k = 4; k >= 1; k--) begin
                if (w_elig[r_last_grant + 2'(k)]) begin
                    w_pick     = r_last_grant + 2'(k);
                    w_pick_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_ld  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_grant_ld  = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (app_req_ack) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign app_req      = (r_state == S_REQ);
    assign app_req_addr = r_addr;
    assign app_req_len  = r_len;
    assign app_req_wr_n = r_wr_n;
    assign p_req_ack    = w_accept ? (4'(1) << r_grant) : 4'b0;

    assign w_wq_push = w_accept & ~r_wr_n;
    assign w_rq_push = w_accept &  r_wr_n;
    assign w_wq_pop  = app_wr_next_req & app_last_wr & ~w_wq_empty;
    assign w_rq_pop  = app_rd_valid & app_last_rd & ~w_rq_empty;

    assign app_wr_data = w_wq_empty ? '0 : p_wr_data[w_wq_head*APP_DW +: APP_DW];
    assign app_wr_en_n = w_wq_empty ? '1 : p_wr_en_n[w_wq_head*APP_BW +: APP_BW];
    assign p_wr_next   = (app_wr_next_req & ~w_wq_empty) ? (4'(1) << w_wq_head) : 4'b0;
    assign p_rd_valid  = (app_rd_valid & ~w_rq_empty) ? (4'(1) << w_rq_head) : 4'b0;
    assign p_last_rd   = (app_last_rd & ~w_rq_empty) ? (4'(1) << w_rq_head) : 4'b0;
    assign p_rd_data   = app_rd_data;

    assign arb_busy   = (r_state == S_REQ) | ~w_wq_empty | ~w_rq_empty;
    assign err_orphan = r_err;

    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= 2'd3;
            r_addr       <= '0;
            r_len        <= '0;
            r_wr_n       <= 1'b0;
            r_err        <= 1'b0;
            r_wq_wp      <= '0;
            r_wq_rp      <= '0;
            r_wq_cnt     <= '0;
            r_rq_wp      <= '0;
            r_rq_rp      <= '0;
            r_rq_cnt     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_ld) begin
                r_grant <= w_pick;
                r_addr  <= p_req_addr[w_pick*APP_AW +: APP_AW];
                r_len   <= p_req_len[w_pick*BL +: BL];
                r_wr_n  <= p_req_wr_n[w_pick];
            end
            if (w_accept) r_last_grant <= r_grant;
            if ((app_wr_next_req & w_wq_empty) | (app_rd_valid & w_rq_empty)) r_err <= 1'b1;

            if (w_wq_push) r_wq_wp <= r_wq_wp + 1'b1;
            if (w_wq_pop)  r_wq_rp <= r_wq_rp + 1'b1;
            if (w_wq_push & ~w_wq_pop)      r_wq_cnt <= r_wq_cnt + 1'b1;
            else if (~w_wq_push & w_wq_pop) r_wq_cnt <= r_wq_cnt - 1'b1;

            if (w_rq_push) r_rq_wp <= r_rq_wp + 1'b1;
            if (w_rq_pop)  r_rq_rp <= r_rq_rp + 1'b1;
            if (w_rq_push & ~w_rq_pop)      r_rq_cnt <= r_rq_cnt + 1'b1;
            else if (~w_rq_push & w_rq_pop) r_rq_cnt <= r_rq_cnt - 1'b1;
        end
    end

    // Tag storage holds no control state, so it is left out of reset.
    always_ff @(posedge sdram_clk) begin
        if (w_wq_push) r_wq[r_wq_wp] <= r_grant;
        if (w_rq_push) r_rq[r_rq_wp] <= r_grant;
    end
endmodule

// File: tb/tb_sdrc_app_arb.sv
// Directed plus randomized bench for sdrc_app_arb, checked against a queue-based
// model of grant order and per-direction data ownership.
module tb_sdrc_app_arb;
    localparam int AW = 30, DW = 32, BW = 4, BLW = 9, TD = 4;

    logic              sdram_clk = 1'b0, sdram_rst = 1'b1, cfg_arb_mode = 1'b0;
    logic [3:0]        p_req = '0, p_req_wr_n = '0;
    logic [AW-1:0]     t_addr  [4];
    logic [BLW-1:0]    t_len   [4];
    logic [DW-1:0]     t_wdata [4];
    logic [BW-1:0]     t_wen   [4];
    logic [4*AW-1:0]   p_req_addr;
    logic [4*BLW-1:0]  p_req_len;
    logic [4*DW-1:0]   p_wr_data;
    logic [4*BW-1:0]   p_wr_en_n;
    logic [3:0]        p_req_ack, p_wr_next, p_rd_valid, p_last_rd;
    logic [DW-1:0]     p_rd_data, app_wr_data;
    logic              app_req, app_req_wr_n, arb_busy, err_orphan;
    logic [AW-1:0]     app_req_addr;
    logic [BLW-1:0]    app_req_len;
    logic [BW-1:0]     app_wr_en_n;
    logic              app_req_ack = 0, app_wr_next_req = 0, app_last_wr = 0;
    logic              app_rd_valid = 0, app_last_rd = 0;
    logic [DW-1:0]     app_rd_data = '0;

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign p_req_addr[g*AW +: AW]  = t_addr[g];
        assign p_req_len[g*BLW +: BLW] = t_len[g];
        assign p_wr_data[g*DW +: DW]   = t_wdata[g];
        assign p_wr_en_n[g*BW +: BW]   = t_wen[g];
    end

    sdrc_app_arb #(.APP_AW(AW), .APP_DW(DW), .APP_BW(BW), .BL(BLW), .TDEPTH(TD)) dut (
        .sdram_clk(sdram_clk), .sdram_rst(sdram_rst), .cfg_arb_mode(cfg_arb_mode),
        .p_req(p_req), .p_req_addr(p_req_addr), .p_req_len(p_req_len),
        .p_req_wr_n(p_req_wr_n), .p_req_ack(p_req_ack), .p_wr_data(p_wr_data),
        .p_wr_en_n(p_wr_en_n), .p_wr_next(p_wr_next), .p_rd_valid(p_rd_valid),
        .p_last_rd(p_last_rd), .p_rd_data(p_rd_data), .app_req(app_req),
        .app_req_addr(app_req_addr), .app_req_len(app_req_len),
        .app_req_wr_n(app_req_wr_n), .app_req_ack(app_req_ack),
        .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n),
        .app_wr_next_req(app_wr_next_req), .app_last_wr(app_last_wr),
        .app_rd_valid(app_rd_valid), .app_last_rd(app_last_rd),
        .app_rd_data(app_rd_data), .arb_busy(arb_busy), .err_orphan(err_orphan)
    );

    always #5 sdram_clk = ~sdram_clk;

    int n_chk = 0, n_fail = 0;
    int last_g = 3;
    int mq_wr[$], mq_rd[$];

    task automatic step();
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference grant choice: direction-full ports are skipped, then RR or fixed order.
    function automatic int pick();
        bit elig[4];
        for (int i = 0; i < 4; i++)
            elig[i] = p_req[i] && (p_req_wr_n[i] ? (mq_rd.size() < TD) : (mq_wr.size() < TD));
        if (cfg_arb_mode) begin
            for (int i = 0; i < 4; i++) if (elig[i]) return i;
        end else begin
            for (int k = 1; k <= 4; k++) if (elig[(last_g + k) % 4]) return (last_g + k) % 4;
        end
        return -1;
    endfunction

    task automatic present(input int p, input bit wr_n);
        t_addr[p]     = AW'($urandom);
        t_len[p]      = BLW'($urandom_range(1, 16));
        p_req_wr_n[p] = wr_n;
        p_req[p]      = 1'b1;
    endtask

    task automatic wait_req(output int cyc);
        cyc = 0;
        while (!app_req && cyc < 12) begin
            step();
            cyc++;
        end
        chk("req_timeout", {127'b0, app_req}, 128'd1);
    endtask

    task automatic accept(input int g, input int delay, input bit pop_rd);
        int h;
        chk("req_addr", app_req_addr, t_addr[g]);
        chk("req_len",  app_req_len,  t_len[g]);
        chk("req_wr_n", app_req_wr_n, p_req_wr_n[g]);
        for (int d = 0; d < delay; d++) begin
            step();
            chk("req_hold", app_req, 1'b1);
        end
        app_req_ack = 1'b1;
        h = -1;
        if (pop_rd && mq_rd.size() > 0) begin
            h = mq_rd[0];
            app_rd_valid = 1'b1;
            app_last_rd  = 1'b1;
        end
        #1;
        chk("req_ack", p_req_ack, 4'(1) << g);
        if (h >= 0) chk("ack_pop_rd_valid", p_rd_valid, 4'(1) << h);
        step();
        app_req_ack  = 1'b0;
        app_rd_valid = 1'b0;
        app_last_rd  = 1'b0;
        if (h >= 0) void'(mq_rd.pop_front());
        last_g = g;
        if (p_req_wr_n[g]) mq_rd.push_back(g); else mq_wr.push_back(g);
        chk("idle_gap", app_req, 1'b0);
    endtask

    task automatic one_req(input int p, input bit wr_n, input int delay);
        int exp_g, cyc;
        present(p, wr_n);
        exp_g = pick();
        wait_req(cyc);
        if (app_req) accept(exp_g, delay, 1'b0);
        p_req[p] = 1'b0;
    endtask

    task automatic wburst(input int n);
        int h;
        h = mq_wr[0];
        for (int w = 0; w < n; w++) begin
            t_wdata[h] = $urandom;
            t_wen[h]   = BW'($urandom);
            app_wr_next_req = 1'b1;
            app_last_wr     = (w == n - 1);
            #1;
            chk("wr_next", p_wr_next, 4'(1) << h);
            chk("wr_data", app_wr_data, t_wdata[h]);
            chk("wr_en_n", app_wr_en_n, t_wen[h]);
            step();
        end
        app_wr_next_req = 1'b0;
        app_last_wr     = 1'b0;
        void'(mq_wr.pop_front());
    endtask

    task automatic rburst(input int n);
        int h;
        h = mq_rd[0];
        for (int w = 0; w < n; w++) begin
            app_rd_data  = $urandom;
            app_rd_valid = 1'b1;
            app_last_rd  = (w == n - 1);
            #1;
            chk("rd_valid", p_rd_valid, 4'(1) << h);
            chk("rd_last",  p_last_rd, (w == n - 1) ? (4'(1) << h) : 4'b0);
            chk("rd_data",  p_rd_data, app_rd_data);
            step();
        end
        app_rd_valid = 1'b0;
        app_last_rd  = 1'b0;
        void'(mq_rd.pop_front());
    endtask

    task automatic do_reset();
        p_req = '0;
        sdram_rst = 1'b1;
        #1;
        chk("rst_app_req", app_req, 1'b0);
        chk("rst_busy", arb_busy, 1'b0);
        step();
        sdram_rst = 1'b0;
        last_g = 3;
        mq_wr.delete();
        mq_rd.delete();
    endtask

    initial begin
        int cyc, exp_g;
        for (int i = 0; i < 4; i++) begin
            t_addr[i] = '0; t_len[i] = '0; t_wdata[i] = $urandom; t_wen[i] = BW'($urandom);
        end
        step(); step();
        chk("rst_p_req_ack", p_req_ack, 4'b0);
        chk("rst_wr_en_n", app_wr_en_n, 4'hF);
        chk("rst_wr_data", app_wr_data, '0);
        chk("rst_err", err_orphan, 1'b0);
        chk("rst_wr_next", p_wr_next, 4'b0);
        chk("rst_rd_valid", p_rd_valid, 4'b0);
        sdram_rst = 1'b0;
        step();

        // Single port-1 write of 4 words, acked two cycles into REQ.
        present(1, 1'b0);
        t_len[1] = 9'd4;
        exp_g = pick();
        wait_req(cyc);
        chk("t1_latency", cyc, 1);
        accept(exp_g, 2, 1'b0);
        p_req[1] = 1'b0;
        chk("t1_busy", arb_busy, 1'b1);
        wburst(4);
        chk("t1_idle_busy", arb_busy, 1'b0);
        chk("t1_wr_en_idle", app_wr_en_n, 4'hF);

        // Round-robin with all four ports requesting continuously.
        do_reset();
        for (int i = 0; i < 4; i++) present(i, (i % 2) == 0);
        for (int n = 0; n < 5; n++) begin
            exp_g = pick();
            wait_req(cyc);
            chk("rr_spacing", cyc, 1);
            accept(exp_g, 0, 1'b0);
        end
        p_req = '0;
        rburst(2); wburst(1); rburst(1); wburst(3); rburst(2);

        // Fixed priority: port 0 keeps winning while 1..3 wait.
        do_reset();
        cfg_arb_mode = 1'b1;
        for (int i = 0; i < 4; i++) present(i, 1'b0);
        for (int n = 0; n < 3; n++) begin
            exp_g = pick();
            wait_req(cyc);
            chk("fp_grant", app_req_addr, t_addr[0]);
            accept(exp_g, 0, 1'b0);
        end
        p_req = '0;
        wburst(1); wburst(2); wburst(1);
        cfg_arb_mode = 1'b0;

        // Back-to-back reads from ports 2 then 0.
        do_reset();
        one_req(2, 1'b1, 0);
        one_req(0, 1'b1, 0);
        rburst(3);
        rburst(2);

        // Read FIFO full: a pending read is masked while a write is granted.
        do_reset();
        for (int i = 0; i < 4; i++) one_req(i, 1'b1, 0);
        present(2, 1'b1);
        present(1, 1'b0);
        exp_g = pick();
        wait_req(cyc);
        chk("full_grant_wr", app_req_wr_n, 1'b0);
        accept(exp_g, 0, 1'b0);
        p_req[1] = 1'b0;
        repeat (3) begin
            step();
            chk("full_masked", app_req, 1'b0);
        end
        p_req[2] = 1'b0;
        rburst(1);
        present(3, 1'b1);
        exp_g = pick();
        wait_req(cyc);
        accept(exp_g, 0, 1'b1);
        p_req[3] = 1'b0;
        one_req(0, 1'b1, 0);
        present(1, 1'b1);
        repeat (3) begin
            step();
            chk("full_again_masked", app_req, 1'b0);
        end
        p_req[1] = 1'b0;
        for (int i = 0; i < 4; i++) rburst(1 + i % 2);
        wburst(2);
        chk("full_drained", arb_busy, 1'b0);

        // Orphan strobe, then reset in the middle of REQ.
        app_rd_valid = 1'b1;
        #1;
        chk("orphan_no_valid", p_rd_valid, 4'b0);
        step();
        app_rd_valid = 1'b0;
        chk("orphan_err", err_orphan, 1'b1);
        present(3, 1'b0);
        wait_req(cyc);
        sdram_rst = 1'b1;
        #1;
        chk("midreq_rst_req", app_req, 1'b0);
        chk("midreq_rst_err", err_orphan, 1'b0);
        p_req = '0;
        step();
        sdram_rst = 1'b0;
        last_g = 3;
        mq_wr.delete();
        mq_rd.delete();
        step();

        // Randomized traffic against the model.
        for (int r = 0; r < 60; r++) begin
            cfg_arb_mode = 1'($urandom);
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 1) == 1) present(i, 1'($urandom));
            exp_g = pick();
            if (exp_g >= 0) begin
                wait_req(cyc);
                if (app_req) accept(exp_g, $urandom_range(0, 2), 1'($urandom));
            end
            p_req = '0;
            if (mq_wr.size() > 0 && $urandom_range(0, 2) == 0) wburst($urandom_range(1, 3));
            if (mq_rd.size() > 0 && $urandom_range(0, 2) == 0) rburst($urandom_range(1, 3));
            step();
        end
        while (mq_wr.size() > 0) wburst(1);
        while (mq_rd.size() > 0) rburst(2);
        chk("rand_drained", arb_busy, 1'b0);
        chk("rand_no_orphan", err_orphan, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
